// File: rtl/ro_puf_pkg.sv
// Shared constants for the RO-PUF response path: FSM state encoding and response width.
package ro_puf_pkg;

    localparam int unsigned RESP_W            = 8;
    localparam int unsigned SETTLE_CYCLES_DEF = 3;

    typedef logic [2:0] state_t;

    localparam state_t StIdle    = 3'd0;
    localparam state_t StSettle  = 3'd1;
    localparam state_t StCount   = 3'd2;
    localparam state_t StCompare = 3'd3;
    localparam state_t StHold    = 3'd4;

endpackage

// File: rtl/ro_response_gen_if.sv
// Start/busy control plus valid/ready response channel of the RO-PUF response generator.
interface ro_response_gen_if;
    import ro_puf_pkg::*;

    logic              start;
    logic              busy;
    logic [RESP_W-1:0] resp_data;
    logic [RESP_W-1:0] resp_tie;
    logic              resp_valid;
    logic              resp_ready;

    modport master (
        input  start,
        input  resp_ready,
        output busy,
        output resp_data,
        output resp_tie,
        output resp_valid
    );

    modport slave (
        output start,
        output resp_ready,
        input  busy,
        input  resp_data,
        input  resp_tie,
        input  resp_valid
    );

endinterface

// File: rtl/ro_edge_counter.sv
// Synchronises one asynchronous RO output, detects rising edges and counts them with saturation.
module ro_edge_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_in,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // [0],[1] form the synchroniser; [2] is the previous synchronised value.
    logic [2:0]       sync_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ro_in};
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ro_response_gen.sv
// Evaluates RO pairs (2k, 2k+1) sequentially over a gate window and packs the
// per-pair comparison results into a response byte with a matching tie mask.
module ro_response_gen
    import ro_puf_pkg::*;
#(
    parameter int unsigned NUM_RO        = 16,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned GATE_CYCLES   = 50000,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_RO-1:0] ro_outputs,
    ro_response_gen_if.master rsp
);

    localparam int unsigned PAIR_W    = $clog2(NUM_RO / 2);
    localparam int unsigned TIMER_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GATE_LOAD   = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [PAIR_W-1:0]  LAST_IDX    = PAIR_W'(NUM_RO / 2 - 1);

    logic [1:0]         rst_sync_q;
    logic               rst_n;
    state_t             state_q, state_d;
    logic [PAIR_W-1:0]  idx_q, idx_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RESP_W-1:0]  data_q, data_d;
    logic [RESP_W-1:0]  tie_q, tie_d;
    logic               ro_a, ro_b;
    logic               cnt_clr, cnt_en;
    logic [CNT_W-1:0]   cnt_a, cnt_b;

    // Asynchronous assertion, release synchronised to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    assign ro_a    = ro_outputs[{idx_q, 1'b0}];
    assign ro_b    = ro_outputs[{idx_q, 1'b1}];
    assign cnt_en  = (state_q == StCount);
    assign cnt_clr = (state_q != StCount) && (state_q != StCompare);

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ro_in (ro_a),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt_a)
    );

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ro_in (ro_b),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt_b)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        data_d  = data_q;
        tie_d   = tie_q;
        case (state_q)
            StIdle: begin
                if (rsp.start) begin
                    state_d = StSettle;
                    idx_d   = '0;
                    timer_d = SETTLE_LOAD;
                end
            end
            StSettle: begin
                if (timer_q == '0) begin
                    state_d = StCount;
                    timer_d = GATE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StCount: begin
                if (timer_q == '0) begin
                    state_d = StCompare;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StCompare: begin
                data_d[idx_q] = (cnt_a > cnt_b);
                tie_d[idx_q]  = (cnt_a == cnt_b);
                if (idx_q == LAST_IDX) begin
                    state_d = StHold;
                end else begin
                    state_d = StSettle;
                    idx_d   = idx_q + 1'b1;
                    timer_d = SETTLE_LOAD;
                end
            end
            StHold: begin
                if (rsp.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
            tie_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            tie_q   <= tie_d;
        end
    end

    assign rsp.busy       = (state_q != StIdle);
    assign rsp.resp_valid = (state_q == StHold);
    assign rsp.resp_data  = data_q;
    assign rsp.resp_tie   = tie_q;

endmodule

// File: tb/tb_ro_response_gen.sv
// Directed bench for ro_response_gen: ordering, ties, saturation, hold behaviour and reset abort.
module tb_ro_response_gen;

    localparam int unsigned LAT   = 8 * (3 + 64 + 1);
    localparam int          BOUND = 700;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] ro;
    int unsigned half [16];
    int unsigned ph = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    // Synthetic ROs: RO i toggles every half[i] clk cycles, all sharing one phase counter.
    always @(negedge clk) ph <= ph + 1;
    always_comb begin
        for (int i = 0; i < 16; i++) ro[i] = ((ph / half[i]) % 2) == 1;
    end

    ro_response_gen_if bus ();
    ro_response_gen_if bus_sat ();

    ro_response_gen #(
        .NUM_RO        (16),
        .CNT_W         (16),
        .GATE_CYCLES   (64),
        .SETTLE_CYCLES (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ro_outputs (ro),
        .rsp        (bus.master)
    );

    ro_response_gen #(
        .NUM_RO        (16),
        .CNT_W         (4),
        .GATE_CYCLES   (64),
        .SETTLE_CYCLES (3)
    ) dut_sat (
        .clk        (clk),
        .reset_n    (reset_n),
        .ro_outputs (ro),
        .rsp        (bus_sat.master)
    );

    task automatic set_halves(input int unsigned he, input int unsigned ho);
        for (int i = 0; i < 16; i++) half[i] = (i % 2 == 0) ? he : ho;
    endtask

    // Pulses start on the selected instance(s); cyc = edges from the sampling edge to resp_valid.
    task automatic run_eval(input bit do_main, input bit do_sat, output int cyc);
        @(negedge clk);
        bus.start     = do_main;
        bus_sat.start = do_sat;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus_sat.start = 1'b0;
        cyc = 0;
        while (cyc < BOUND) begin
            @(posedge clk);
            #1;
            cyc++;
            if (do_main ? bus.resp_valid : bus_sat.resp_valid) break;
        end
    endtask

    task automatic accept();
        @(negedge clk);
        bus.resp_ready     = 1'b1;
        bus_sat.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready     = 1'b0;
        bus_sat.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.resp_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", bus.resp_data); end
        n_checks++; if (bus.resp_tie !== 8'h00) begin n_fail++; $display("FAIL reset_tie got %h want 00", bus.resp_tie); end
        n_checks++; if (bus_sat.busy !== 1'b0) begin n_fail++; $display("FAIL reset_sat_busy got %b want 0", bus_sat.busy); end
        n_checks++; if (bus_sat.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sat_valid got %b want 0", bus_sat.resp_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got %b want 0", bus.busy); end
    endtask

    task automatic test_even_faster();
        int cyc;
        set_halves(2, 3);
        run_eval(1'b1, 1'b0, cyc);
        n_checks++; if (cyc != LAT) begin n_fail++; $display("FAIL latency got %0d want %0d", cyc, LAT); end
        n_checks++; if (bus.resp_data !== 8'hFF) begin n_fail++; $display("FAIL even_fast_data got %h want ff", bus.resp_data); end
        n_checks++; if (bus.resp_tie !== 8'h00) begin n_fail++; $display("FAIL even_fast_tie got %h want 00", bus.resp_tie); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy got %b want 1", bus.busy); end
        accept();
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL accept_valid got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL accept_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_odd_faster();
        int cyc;
        set_halves(3, 2);
        run_eval(1'b1, 1'b0, cyc);
        n_checks++; if (bus.resp_data !== 8'h00) begin n_fail++; $display("FAIL odd_fast_data got %h want 00", bus.resp_data); end
        n_checks++; if (bus.resp_tie !== 8'h00) begin n_fail++; $display("FAIL odd_fast_tie got %h want 00", bus.resp_tie); end
        accept();
        // Pair k: even RO faster when k is even.
        for (int k = 0; k < 8; k++) begin
            half[2*k]   = (k % 2 == 0) ? 2 : 3;
            half[2*k+1] = (k % 2 == 0) ? 3 : 2;
        end
        run_eval(1'b1, 1'b0, cyc);
        n_checks++; if (cyc != LAT) begin n_fail++; $display("FAIL alt_latency got %0d want %0d", cyc, LAT); end
        n_checks++; if (bus.resp_data !== 8'h55) begin n_fail++; $display("FAIL alt_data got %h want 55", bus.resp_data); end
        n_checks++; if (bus.resp_tie !== 8'h00) begin n_fail++; $display("FAIL alt_tie got %h want 00", bus.resp_tie); end
        accept();
    endtask

    task automatic test_equal();
        int cyc;
        set_halves(2, 2);
        run_eval(1'b1, 1'b0, cyc);
        n_checks++; if (bus.resp_data !== 8'h00) begin n_fail++; $display("FAIL equal_data got %h want 00", bus.resp_data); end
        n_checks++; if (bus.resp_tie !== 8'hFF) begin n_fail++; $display("FAIL equal_tie got %h want ff", bus.resp_tie); end
        accept();
    endtask

    task automatic test_hold();
        int cyc;
        set_halves(2, 3);
        run_eval(1'b1, 1'b0, cyc);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.start = (i % 10 == 5);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 8'hFF || bus.resp_tie !== 8'h00) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d got v=%b d=%h t=%h want v=1 d=ff t=00",
                         i, bus.resp_valid, bus.resp_data, bus.resp_tie);
            end
        end
        // Handshake and start in the same cycle: start must be dropped.
        @(negedge clk);
        bus.resp_ready = 1'b1;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        bus.start      = 1'b0;
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL hold_release_busy got %b want 0", bus.busy); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_not_queued got %b want 0", bus.busy); end
        n_checks++; if (bus.resp_data !== 8'hFF) begin n_fail++; $display("FAIL idle_data_held got %h want ff", bus.resp_data); end
    endtask

    task automatic test_saturation();
        int cyc;
        set_halves(1, 2);
        run_eval(1'b1, 1'b1, cyc);
        n_checks++; if (cyc != LAT) begin n_fail++; $display("FAIL sat_latency got %0d want %0d", cyc, LAT); end
        n_checks++; if (bus_sat.resp_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid got %b want 1", bus_sat.resp_valid); end
        n_checks++; if (bus_sat.resp_data !== 8'h00) begin n_fail++; $display("FAIL sat_data got %h want 00", bus_sat.resp_data); end
        n_checks++; if (bus_sat.resp_tie !== 8'hFF) begin n_fail++; $display("FAIL sat_tie got %h want ff", bus_sat.resp_tie); end
        n_checks++; if (bus.resp_data !== 8'hFF) begin n_fail++; $display("FAIL wide_data got %h want ff", bus.resp_data); end
        n_checks++; if (bus.resp_tie !== 8'h00) begin n_fail++; $display("FAIL wide_tie got %h want 00", bus.resp_tie); end
        accept();
    endtask

    task automatic test_reset_mid_count();
        int cyc;
        set_halves(3, 2);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        // Land inside the counting window of pair 3.
        repeat (3 * 68 + 3 + 20) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", bus.busy); end
        n_checks++; if (bus.resp_data !== 8'hF8) begin n_fail++; $display("FAIL mid_partial got %h want f8", bus.resp_data); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.resp_data !== 8'h00) begin n_fail++; $display("FAIL abort_data got %h want 00", bus.resp_data); end
        n_checks++; if (bus.resp_tie !== 8'h00) begin n_fail++; $display("FAIL abort_tie got %h want 00", bus.resp_tie); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        set_halves(2, 3);
        run_eval(1'b1, 1'b0, cyc);
        n_checks++; if (cyc != LAT) begin n_fail++; $display("FAIL fresh_latency got %0d want %0d", cyc, LAT); end
        n_checks++; if (bus.resp_data !== 8'hFF) begin n_fail++; $display("FAIL fresh_data got %h want ff", bus.resp_data); end
        accept();
    endtask

    initial begin
        set_halves(2, 2);
        bus.start          = 1'b0;
        bus.resp_ready     = 1'b0;
        bus_sat.start      = 1'b0;
        bus_sat.resp_ready = 1'b0;
        test_reset();
        test_even_faster();
        test_odd_faster();
        test_equal();
        test_hold();
        test_saturation();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_response_gen.md
Name: ro_response_gen

Overview:
Converts the free-running ring-oscillator outputs of the RO-PUF into a packed PUF response byte. Evaluates fixed RO pairs (2k, 2k+1) one at a time over a gate window and compares their edge counts. Delivers one response bit per pair, plus a tie mask, over a valid/ready handshake. Sits between the RO array and the UART byte transmitter.

Parameters:
NUM_RO, 16, number of RO inputs; must be even; pairs = NUM_RO/2 = 8, fixed for 8-bit output
CNT_W, 16, width of each edge counter; counters saturate at 2^CNT_W-1
GATE_CYCLES, 50000, clk cycles per counting window; >= 1
SETTLE_CYCLES, 3, cycles discarded after selecting a new pair (synchronizer flush)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ro_outputs  in  NUM_RO  raw RO outputs, asynchronous to clk
start  in  1  single-cycle request for a new evaluation; honoured only in IDLE
busy  out  1  high in every state except IDLE
resp_data  out  8  response byte; bit k = pair k result
resp_tie  out  8  bit k set when pair k counts were equal
resp_valid  out  1  response available; held until accepted
resp_ready  in  1  consumer accepts on resp_valid & resp_ready

Behaviour:
- Reset (async assert, sync-release inside the block): state IDLE, busy=0, resp_valid=0, resp_data=0, resp_tie=0, pair index=0, counters=0.
- Sampling: the selected pair is muxed by pair index into two 2-flop synchronizers followed by a rising-edge detector. Each detected edge increments its counter by 1, saturating at all-ones (no wrap).
- FSM states: IDLE, SETTLE, COUNT, COMPARE, HOLD.
- IDLE: start=1 -> SETTLE, pair index=0, counters cleared. start=0 -> stay.
- SETTLE: counters held at 0, edges ignored, for exactly SETTLE_CYCLES cycles -> COUNT.
- COUNT: counters enabled for exactly GATE_CYCLES cycles -> COMPARE.
- COMPARE (1 cycle): bit[idx] = (cnt_a > cnt_b), tie[idx] = (cnt_a == cnt_b). A tie gives bit 0. Counters clear. If idx==7 -> HOLD; else idx+1 -> SETTLE.
- HOLD: resp_valid=1, resp_data/resp_tie stable. On resp_ready=1 -> IDLE, resp_valid drops the next cycle. resp_data holds its last value in IDLE.
- Latency: resp_valid rises exactly 8*(SETTLE_CYCLES+GATE_CYCLES+1) cycles after the cycle in which start is sampled in IDLE.
- start outside IDLE is ignored and not queued. This includes start in the same cycle as the HOLD handshake.
- resp_ready outside HOLD has no effect.
- reset_n low at any point, including mid-COUNT or in HOLD, aborts immediately to reset values. The partial result is discarded.
- Both counters of a pair count in the same cycles. The comparison is unsigned on CNT_W bits.

Decomposition:
- Shared package ro_puf_pkg: FSM state enum, SETTLE_CYCLES default, RESP_W=8 constant.
- One sub-module, ro_edge_counter: 2-flop synchronizer, rising-edge detect, saturating CNT_W counter with clear and enable. Instantiated twice (A = even RO, B = odd RO).
- The pair mux and FSM stay in ro_response_gen.

Test Plan:
- GATE_CYCLES=64, even ROs toggle every 2 clk, odd every 3 clk; pulse start. Required: resp_valid at exactly 8*(3+64+1)=544 cycles; resp_data=0xFF, resp_tie=0x00.
- Same setup with even/odd periods swapped. Required: resp_data=0x00, resp_tie=0x00. Then alternate faster RO per pair (pair k even faster when k even). Required: resp_data=0x55.
- All ROs identical period-4 waveform in phase. Required: resp_data=0x00, resp_tie=0xFF.
- Hold resp_ready=0 for 100 cycles after resp_valid, pulsing start meanwhile. Required: resp_valid and data stable, start ignored. Raise resp_ready: resp_valid falls the next cycle, busy=0.
- CNT_W=4, GATE_CYCLES=64, fast RO vs slower RO both exceeding 15 edges. Required: both counters saturate at 15, tie bit set, bit=0.
- Assert reset_n low mid-COUNT of pair 3. Required: busy=0, resp_valid=0, resp_data=0 immediately; a new start produces a full fresh 544-cycle evaluation.
